// File: rtl/carpma_pkg.sv
// carpma_pkg: shared defaults and state encoding for the calculator datapath
package carpma_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_FRAC = 16;
  localparam int DEF_OVF_LSB = DEF_WIDTH + DEF_FRAC;
  typedef enum logic {IDLE, CALC} state_e;
endpackage

// File: rtl/carpma.sv
// carpma: sequential unsigned QI.F x QI.F shift-add multiplier, one multiplier bit per clock
module carpma
  import carpma_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC = DEF_FRAC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               basla,
  input  logic [WIDTH-1:0]   carpilan,
  input  logic [WIDTH-1:0]   carpan,
  output logic [2*WIDTH-1:0] sonuc,
  output logic [WIDTH-1:0]   sonuc_q,
  output logic               hazir,
  output logic               gecerli,
  output logic               tasma
);
  localparam int CW = $clog2(WIDTH);
  state_e state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, res_q, res_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic gec_q, gec_d;
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    gec_d = 1'b0;
    if (state_q == IDLE) begin
      if (basla) begin
        if (carpilan == '0 || carpan == '0) begin
          res_d = '0;
          gec_d = 1'b1;
        end else begin
          a_d = carpilan;
          b_d = carpan;
          acc_d = '0;
          cnt_d = '0;
          state_d = CALC;
        end
      end
    end else begin
      acc_d = acc_q + (b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        res_d = acc_d;
        gec_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      gec_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      gec_q <= gec_d;
    end
  end
  // overflow is any bit above the QI.F window of the held product
  assign sonuc = res_q;
  assign sonuc_q = res_q[WIDTH+FRAC-1:FRAC];
  assign tasma = |res_q[2*WIDTH-1:WIDTH+FRAC];
  assign hazir = (state_q == IDLE);
  assign gecerli = gec_q;
endmodule
